// File: rtl/uart_avalon_slave.sv
// Avalon-MM slave UART (8N1): RX data at 0x0, TX data at 0x4, status at 0x8.
// Define UART_RX_FIFO_EN to replace the RX holding register with an RX_FIFO_DEPTH-entry FIFO.
module uart_avalon_slave #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic [4:0]  avm_address,
  input  logic        avm_read,
  output logic [31:0] avm_readdata,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  output logic        avm_waitrequest,
  input  logic        uart_rxd,
  output logic        uart_txd
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [4:0] ADDR_RX = 5'd0, ADDR_TX = 5'd4, ADDR_STAT = 5'd8;

  typedef enum logic {BUS_IDLE, BUS_ACK} busState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;

  busState_t busState_q, busState_d;
  logic [4:0] addr_q;
  logic       isWrite_q;
  logic [7:0] wdata_q;
  logic       busDone, txStall, txOk, rxRdDone, statRdDone, txWrDone;
  logic [7:0] rxHead, rxLevel;
  logic       rxAvail, rxOverrun;
  logic       frameErr_q, overrun_q;
  logic       unusedWdata;

  assign unusedWdata = ^avm_writedata[31:8];

  // Bus: latch the request in its first cycle, complete in the second unless a TX write must stall.
  assign txStall    = isWrite_q && (addr_q == ADDR_TX) && !txOk;
  assign busDone    = (busState_q == BUS_ACK) && !txStall;
  assign rxRdDone   = busDone && !isWrite_q && (addr_q == ADDR_RX);
  assign statRdDone = busDone && !isWrite_q && (addr_q == ADDR_STAT);
  assign txWrDone   = busDone && isWrite_q && (addr_q == ADDR_TX);

  always_comb begin
    busState_d      = busState_q;
    avm_waitrequest = 1'b1;
    avm_readdata    = 32'h0;
    case (busState_q)
      BUS_IDLE: if (avm_read || avm_write) busState_d = BUS_ACK;
      BUS_ACK: begin
        if (busDone) begin
          avm_waitrequest = 1'b0;
          busState_d      = BUS_IDLE;
          if (!isWrite_q && addr_q == ADDR_RX)
            avm_readdata = {24'h0, rxAvail ? rxHead : 8'h0};
          else if (!isWrite_q && addr_q == ADDR_STAT)
            avm_readdata = {16'h0, rxLevel, rxAvail, txOk, 4'h0, frameErr_q, overrun_q};
        end
      end
    endcase
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      busState_q <= BUS_IDLE;
      addr_q     <= 5'd0;
      isWrite_q  <= 1'b0;
      wdata_q    <= 8'h0;
    end else begin
      busState_q <= busState_d;
      if (busState_q == BUS_IDLE && (avm_read || avm_write)) begin
        addr_q    <= avm_address;
        isWrite_q <= avm_write;
        wdata_q   <= avm_writedata[7:0];
      end
    end
  end

  // Transmitter: each of start, 8 data (LSB first) and stop is held CLKS_PER_BIT cycles.
  txState_t         txState_q, txState_d;
  logic [CNT_W-1:0] txCnt_q, txCnt_d;
  logic [7:0]       txShift_q, txShift_d;
  logic [2:0]       txIdx_q, txIdx_d;
  logic             txd_q, txd_d;

  assign txOk     = (txState_q == TX_IDLE);
  assign uart_txd = txd_q;

  always_comb begin
    txState_d = txState_q;
    txCnt_d   = txCnt_q;
    txShift_d = txShift_q;
    txIdx_d   = txIdx_q;
    txd_d     = txd_q;
    case (txState_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (txWrDone) begin
          txState_d = TX_START;
          txShift_d = wdata_q;
          txCnt_d   = '0;
          txd_d     = 1'b0;
        end
      end
      TX_START: begin
        txCnt_d = txCnt_q + 1'b1;
        if (txCnt_q == BIT_LAST) begin
          txState_d = TX_DATA;
          txCnt_d   = '0;
          txIdx_d   = 3'd0;
          txd_d     = txShift_q[0];
        end
      end
      TX_DATA: begin
        txCnt_d = txCnt_q + 1'b1;
        if (txCnt_q == BIT_LAST) begin
          txCnt_d   = '0;
          txIdx_d   = txIdx_q + 3'd1;
          txShift_d = {1'b0, txShift_q[7:1]};
          txd_d     = txShift_q[1];
          if (txIdx_q == 3'd7) begin
            txState_d = TX_STOP;
            txd_d     = 1'b1;
          end
        end
      end
      TX_STOP: begin
        txCnt_d = txCnt_q + 1'b1;
        if (txCnt_q == BIT_LAST) begin
          txState_d = TX_IDLE;
          txCnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      txState_q <= TX_IDLE;
      txCnt_q   <= '0;
      txShift_q <= 8'h0;
      txIdx_q   <= 3'd0;
      txd_q     <= 1'b1;
    end else begin
      txState_q <= txState_d;
      txCnt_q   <= txCnt_d;
      txShift_q <= txShift_d;
      txIdx_q   <= txIdx_d;
      txd_q     <= txd_d;
    end
  end

  // Receiver: synchronised falling edge starts a frame, bits sampled mid-bit.
  rxState_t         rxState_q, rxState_d;
  logic [CNT_W-1:0] rxCnt_q, rxCnt_d;
  logic [7:0]       rxShift_q, rxShift_d;
  logic [2:0]       rxIdx_q, rxIdx_d;
  logic             rxSync1_q, rxSync2_q, rxPrev_q;
  logic             rxGood, rxBad;

  always_comb begin
    rxState_d = rxState_q;
    rxCnt_d   = rxCnt_q;
    rxShift_d = rxShift_q;
    rxIdx_d   = rxIdx_q;
    rxGood    = 1'b0;
    rxBad     = 1'b0;
    case (rxState_q)
      RX_IDLE: begin
        if (rxPrev_q && !rxSync2_q) begin
          rxState_d = RX_START;
          rxCnt_d   = '0;
        end
      end
      RX_START: begin
        rxCnt_d = rxCnt_q + 1'b1;
        if (rxCnt_q == HALF_LAST) begin
          rxCnt_d   = '0;
          rxIdx_d   = 3'd0;
          rxState_d = rxSync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        rxCnt_d = rxCnt_q + 1'b1;
        if (rxCnt_q == BIT_LAST) begin
          rxCnt_d   = '0;
          rxShift_d = {rxSync2_q, rxShift_q[7:1]};
          rxIdx_d   = rxIdx_q + 3'd1;
          if (rxIdx_q == 3'd7) rxState_d = RX_STOP;
        end
      end
      RX_STOP: begin
        rxCnt_d = rxCnt_q + 1'b1;
        if (rxCnt_q == BIT_LAST) begin
          rxCnt_d   = '0;
          rxState_d = RX_IDLE;
          rxGood    = rxSync2_q;
          rxBad     = !rxSync2_q;
        end
      end
    endcase
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      rxState_q <= RX_IDLE;
      rxCnt_q   <= '0;
      rxShift_q <= 8'h0;
      rxIdx_q   <= 3'd0;
      rxSync1_q <= 1'b1;
      rxSync2_q <= 1'b1;
      rxPrev_q  <= 1'b1;
    end else begin
      rxState_q <= rxState_d;
      rxCnt_q   <= rxCnt_d;
      rxShift_q <= rxShift_d;
      rxIdx_q   <= rxIdx_d;
      rxSync1_q <= uart_rxd;
      rxSync2_q <= rxSync1_q;
      rxPrev_q  <= rxSync2_q;
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  logic [7:0]  fifoMem_q [RX_FIFO_DEPTH];
  logic [AW:0] wrPtr_q, rdPtr_q, fill;
  logic        full, rxPop, rxPush;

  // A full FIFO still accepts a byte when a pop completes in the same cycle.
  assign fill      = wrPtr_q - rdPtr_q;
  assign full      = (fill == (AW+1)'(RX_FIFO_DEPTH));
  assign rxAvail   = (wrPtr_q != rdPtr_q);
  assign rxPop     = rxRdDone && rxAvail;
  assign rxPush    = rxGood && (!full || rxPop);
  assign rxOverrun = rxGood && full && !rxPop;
  assign rxHead    = fifoMem_q[rdPtr_q[AW-1:0]];
  assign rxLevel   = 8'(fill);

  always_ff @(posedge avm_clk) begin
    if (rxPush) fifoMem_q[wrPtr_q[AW-1:0]] <= rxShift_q;
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (rxPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (rxPop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end
`else
  localparam int unusedDepth = RX_FIFO_DEPTH;
  logic [7:0] rxHold_q;
  logic       rxOk_q;

  // A new byte always wins; it only counts as overrun if the old one is not popped this cycle.
  assign rxAvail   = rxOk_q;
  assign rxHead    = rxHold_q;
  assign rxLevel   = 8'h0;
  assign rxOverrun = rxGood && rxOk_q && !rxRdDone;

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      rxHold_q <= 8'h0;
      rxOk_q   <= 1'b0;
    end else if (rxGood) begin
      rxHold_q <= rxShift_q;
      rxOk_q   <= 1'b1;
    end else if (rxRdDone) begin
      rxOk_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (statRdDone) begin
        frameErr_q <= 1'b0;
        overrun_q  <= 1'b0;
      end
      if (rxBad)     frameErr_q <= 1'b1;
      if (rxOverrun) overrun_q  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_avalon_slave.sv
// Directed bench for uart_avalon_slave at 16 clocks per bit; expected read data and
// serial bits are queued when stimulus is driven and compared when the DUT produces them.
`timescale 1ns/1ps
module tb_uart_avalon_slave;
  localparam int CPB   = 16;
  localparam int LIMIT = 400;
`ifdef UART_RX_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic        avm_clk = 1'b0;
  logic        avm_rst;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic        uart_rxd;
  logic        uart_txd;

  int total = 0;
  int bad   = 0;
  logic [31:0] expQ[$];
  string       tagQ[$];

  uart_avalon_slave #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(4)) dut (
    .avm_clk        (avm_clk),
    .avm_rst        (avm_rst),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .uart_rxd       (uart_rxd),
    .uart_txd       (uart_txd)
  );

  always #5 avm_clk = ~avm_clk;

  // Expected STATUS word; occupancy only shows when the RX FIFO is built in.
  function automatic logic [31:0] stat(input logic rxOk, input logic txOk, input logic fe,
                                       input logic ov, input int occ);
    logic [7:0] occByte;
    occByte = FIFO_EN ? occ[7:0] : 8'h0;
    return {16'h0, occByte, rxOk, txOk, 4'h0, fe, ov};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus transfer; waits counts falling edges until waitrequest is seen low.
  task automatic applyStimulus(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output int waits);
    avm_address   = addr;
    avm_writedata = wdata;
    avm_write     = wr;
    avm_read      = !wr;
    waits = 0;
    do begin
      @(negedge avm_clk);
      waits++;
    end while (avm_waitrequest && waits < LIMIT);
    rdata = avm_readdata;
    @(negedge avm_clk);
    avm_read  = 1'b0;
    avm_write = 1'b0;
  endtask

  task automatic readReg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    int w;
    expQ.push_back(exp);
    tagQ.push_back(tag);
    applyStimulus(1'b0, addr, 32'h0, rd, w);
    checkOutput({tag, "_waits"}, 32'(w), 32'd1);
    checkOutput(tagQ.pop_front(), rd, expQ.pop_front());
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = bits[i];
      repeat (CPB) @(negedge avm_clk);
    end
    uart_rxd = 1'b1;
    repeat (4) @(negedge avm_clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [9:0]  txFrame;
    int          w;
    avm_rst = 1'b1; avm_address = 5'd0; avm_read = 1'b0; avm_write = 1'b0;
    avm_writedata = 32'h0; uart_rxd = 1'b1;
    repeat (3) @(negedge avm_clk);
    checkOutput("rst_waitreq", 32'(avm_waitrequest), 32'd1);
    checkOutput("rst_readdata", avm_readdata, 32'h0);
    checkOutput("rst_txd", 32'(uart_txd), 32'd1);
    avm_rst = 1'b0;
    @(negedge avm_clk);

    $display("[TB] status after reset");
    avm_address = 5'd8; avm_read = 1'b1;
    #1 checkOutput("stat_cycle1_waitreq", 32'(avm_waitrequest), 32'd1);
    readReg("stat_reset", 5'd8, stat(1'b0, 1'b1, 1'b0, 1'b0, 0));

    $display("[TB] receive 0xA5");
    sendFrame(8'hA5, 1'b1);
    readReg("stat_a5", 5'd8, stat(1'b1, 1'b1, 1'b0, 1'b0, 1));
    readReg("rx_a5", 5'd0, 32'hA5);
    readReg("stat_popped", 5'd8, stat(1'b0, 1'b1, 1'b0, 1'b0, 0));

    $display("[TB] two frames without reading");
    sendFrame(8'h11, 1'b1);
    sendFrame(8'h22, 1'b1);
`ifdef UART_RX_FIFO_EN
    readReg("rx_11", 5'd0, 32'h11);
    readReg("rx_22", 5'd0, 32'h22);
    readReg("stat_no_overrun", 5'd8, stat(1'b0, 1'b1, 1'b0, 1'b0, 0));
`else
    readReg("rx_22", 5'd0, 32'h22);
    readReg("stat_overrun", 5'd8, stat(1'b0, 1'b1, 1'b0, 1'b1, 0));
    readReg("stat_overrun_clr", 5'd8, stat(1'b0, 1'b1, 1'b0, 1'b0, 0));
`endif

    $display("[TB] frame with bad stop bit");
    sendFrame(8'h55, 1'b0);
    readReg("rx_empty", 5'd0, 32'h0);
    readReg("stat_frame_err", 5'd8, stat(1'b0, 1'b1, 1'b1, 1'b0, 0));
    readReg("stat_frame_err_clr", 5'd8, stat(1'b0, 1'b1, 1'b0, 1'b0, 0));

    $display("[TB] short glitch");
    uart_rxd = 1'b0;
    repeat (8) @(negedge avm_clk);
    uart_rxd = 1'b1;
    repeat (12 * CPB) @(negedge avm_clk);
    readReg("stat_glitch", 5'd8, stat(1'b0, 1'b1, 1'b0, 1'b0, 0));

    $display("[TB] transmit 0x3C");
    checkOutput("txd_idle", 32'(uart_txd), 32'd1);
    txFrame = {1'b1, 8'h3C, 1'b0};
    for (int i = 0; i < 10; i++) begin
      expQ.push_back(32'(txFrame[i]));
      tagQ.push_back($sformatf("txbit%0d", i));
    end
    applyStimulus(1'b1, 5'd4, 32'h0000_013C, rd, w);
    checkOutput("tx_wr_waits", 32'(w), 32'd1);
    repeat (CPB / 2) @(negedge avm_clk);
    for (int i = 0; i < 10; i++) begin
      checkOutput(tagQ.pop_front(), 32'(uart_txd), expQ.pop_front());
      if (i < 9) repeat (CPB) @(negedge avm_clk);
    end
    repeat (CPB) @(negedge avm_clk);

    $display("[TB] back-to-back writes and reset mid-frame");
    applyStimulus(1'b1, 5'd4, 32'h0000_0000, rd, w);
    checkOutput("tx2_wr_waits", 32'(w), 32'd1);
    readReg("stat_tx_busy", 5'd8, stat(1'b0, 1'b0, 1'b0, 1'b0, 0));
    applyStimulus(1'b1, 5'd4, 32'h0000_0000, rd, w);
    checkOutput("tx3_stalled", 32'(w >= 150 && w <= 165), 32'd1);
    repeat (3 * CPB) @(negedge avm_clk);
    checkOutput("txd_mid_frame", 32'(uart_txd), 32'd0);
    avm_rst = 1'b1;
    @(negedge avm_clk);
    checkOutput("rst_mid_txd", 32'(uart_txd), 32'd1);
    checkOutput("rst_mid_waitreq", 32'(avm_waitrequest), 32'd1);
    @(negedge avm_clk);
    avm_rst = 1'b0;
    @(negedge avm_clk);
    readReg("stat_after_rst", 5'd8, stat(1'b0, 1'b1, 1'b0, 1'b0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
